alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter WIDTH, default 8, data width of ALU results.
REQ-002 Parameter NREGS, default 8, register-file entries; REG_AW = $clog2(NREGS).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ex_valid  input  1  execute stage presents a result.
REQ-006 ex_ready  output  1  writeback can accept a result.
REQ-007 ex_rd  input  REG_AW  destination register index.
REQ-008 ex_result  input  WIDTH  arithmetic result from the execute stage.
REQ-009 ex_div0  input  1  result came from a DIV with divisor zero.
REQ-010 rf_we  output  1  register-file write request.
REQ-011 rf_waddr  output  REG_AW  write address.
REQ-012 rf_wdata  output  WIDTH  write data.
REQ-013 rf_wr_ready  input  1  register-file port grants the write this cycle.
REQ-014 pending  output  NREGS  bit i = some buffered entry targets register i (hazard check upstream).
REQ-015 wb_count  output  2  buffered entries, 0..2.
REQ-016 err_clr  input  1  clears the sticky error.
REQ-017 err_div0  output  1  sticky divide-by-zero flag.
REQ-018 err_rd  output  REG_AW  ex_rd of the first dropped div-by-zero result since last clear.

Function
REQ-019 Results SHALL be held in a 2-entry FIFO {rd, result, div0}, in-order.
REQ-020 ex_ready SHALL equal (wb_count != 2), independent of ex_valid; no same-cycle full bypass.
REQ-021 Push SHALL occur on ex_valid && ex_ready; ex_rd/ex_result/ex_div0 captured that edge.
REQ-022 Head entry is "droppable" when div0=1 or rd=0 (register 0 hardwired zero).
REQ-023 rf_we SHALL be 1 iff FIFO non-empty and head not droppable; rf_waddr/rf_wdata = head fields (0 when rf_we=0).
REQ-024 Pop SHALL occur on (rf_we && rf_wr_ready) or (non-empty && head droppable); droppable entries pop in one cycle without writing.
REQ-025 Latency: result pushed at edge N SHALL drive rf_we in cycle N+1 when FIFO was empty; no combinational path ex_* -> rf_*.
REQ-026 Simultaneous push and pop SHALL leave wb_count unchanged, both operations performed.
REQ-027 rf_we held with rf_wr_ready=0 SHALL keep rf_waddr/rf_wdata stable until granted.
REQ-028 pending SHALL be the OR of one-hot(rd) over valid entries, combinational from FIFO state; rd=0 entries contribute no bit.
REQ-029 Popping a div0 head SHALL set err_div0; err_rd loads head rd only if err_div0 was 0.
REQ-030 err_clr SHALL clear err_div0 and err_rd; a div0 pop in the same cycle wins (flag set, err_rd = that rd).
REQ-031 Read/write pointers SHALL be 1-bit and wrap 1->0.

Reset
REQ-032 rst SHALL asynchronously clear pointers, wb_count=0, err_div0=0, err_rd=0; hence rf_we=0, pending=0, ex_ready=1.
REQ-033 rst mid-operation SHALL discard buffered entries without any register write.

Structure
REQ-034 Shared package SHALL hold the wb entry struct type and FIFO depth constant (2).
REQ-035 One sub-module is natural: wb_fifo2 (2-entry synchronous FIFO, full/empty/count); hazard mask and error logic remain in alu_writeback.

Verification
REQ-036 Single: push rd=3, result=0x2A, rf_wr_ready=1 -> next cycle rf_we=1, waddr=3, wdata=0x2A, pending=0x08; following cycle wb_count=0.
REQ-037 Backpressure: rf_wr_ready=0, push rd=1/0x11 then rd=2/0x22 -> wb_count=2, ex_ready=0, pending=0x06; raise ready -> writes 0x11 then 0x22 in order.
REQ-038 Div0: push rd=5, div0=1 -> no rf_we, entry popped in 1 cycle, err_div0=1, err_rd=5; second div0 rd=6 -> err_rd stays 5; err_clr -> both 0.
REQ-039 rd=0: push rd=0, result=0xFF -> no rf_we, pending stays 0, wb_count returns to 0.
REQ-040 Simultaneous push/pop at wb_count=1 -> wb_count stays 1, order preserved; assert rst with 2 entries -> rf_we=0, wb_count=0 immediately.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage.
//   WB_WIDTH / WB_NREGS : default result width and register count
//   WB_DEPTH            : depth of the writeback buffer (fixed at 2)
//   WB_CNT_W            : width of the occupancy count (holds 0..2)
//   wb_entry_t          : buffered entry {rd, result, div0} at default widths
package alu_writeback_pkg;

  localparam int WB_WIDTH = 8;
  localparam int WB_NREGS = 8;
  localparam int WB_AW    = $clog2(WB_NREGS);
  localparam int WB_DEPTH = 2;
  localparam int WB_CNT_W = 2;

  typedef struct packed {
    logic [WB_AW-1:0]    rd;
    logic [WB_WIDTH-1:0] result;
    logic                div0;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Execute-to-writeback and writeback-to-register-file signal bundle.
//   ex_*   : result handshake from the execute stage (valid/ready)
//   rf_*   : register-file write request and grant
// Modports: master = execute stage / register file side, slave = writeback.
interface alu_writeback_if
  import alu_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int NREGS = WB_NREGS
);
  localparam int REG_AW = $clog2(NREGS);

  logic              ex_valid;
  logic              ex_ready;
  logic [REG_AW-1:0] ex_rd;
  logic [WIDTH-1:0]  ex_result;
  logic              ex_div0;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;
  logic              rf_wr_ready;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_div0, rf_wr_ready,
    input  ex_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_div0, rf_wr_ready,
    output ex_ready, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/alu_writeback_wb_fifo2.sv
// Two-entry in-order synchronous FIFO with 1-bit wrapping pointers.
//   clk, rst            : clock, async active-high reset
//   push, push_data     : write (ignored when full)
//   pop                 : read-advance (ignored when empty)
//   slots, slot_valid   : raw storage and per-slot occupancy
//   rd_ptr              : index of the head slot
//   full, empty, count  : occupancy status
module wb_fifo2
  import alu_writeback_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  entry_t              push_data,
  input  logic                pop,
  output entry_t              slots [WB_DEPTH],
  output logic [WB_DEPTH-1:0] slot_valid,
  output logic                rd_ptr,
  output logic                full,
  output logic                empty,
  output logic [WB_CNT_W-1:0] count
);

  entry_t              mem_q [WB_DEPTH];
  entry_t              mem_d [WB_DEPTH];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [WB_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full    = (count_q == WB_CNT_W'(WB_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head slot is occupied whenever non-empty; the other slot only when full.
  always_comb begin
    slot_valid            = '0;
    slot_valid[rd_ptr_q]  = !empty;
    slot_valid[~rd_ptr_q] = full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign slots  = mem_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers execute results in a 2-entry FIFO and retires
// them in order to the register file. Entries targeting r0 or flagged as a
// divide-by-zero are discarded in a single cycle without writing.
//   clk, rst   : clock, async active-high reset
//   wb_if      : ex_* result handshake and rf_* write port (slave side)
//   pending    : bit i set while a buffered entry targets register i (i != 0)
//   wb_count   : buffered entries (0..2)
//   err_clr    : clears the sticky divide-by-zero error
//   err_div0   : sticky divide-by-zero flag
//   err_rd     : destination of the first dropped div-by-zero since last clear
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter  int WIDTH  = WB_WIDTH,
  parameter  int NREGS  = WB_NREGS,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  alu_writeback_if.slave      wb_if,
  output logic [NREGS-1:0]    pending,
  output logic [WB_CNT_W-1:0] wb_count,
  input  logic                err_clr,
  output logic                err_div0,
  output logic [REG_AW-1:0]   err_rd
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  result;
    logic              div0;
  } entry_t;

  entry_t                slots [WB_DEPTH];
  entry_t                head;
  entry_t                push_entry;
  logic [WB_DEPTH-1:0]   slot_valid;
  logic                  rd_ptr;
  logic                  full, empty;
  logic                  push, pop;
  logic                  droppable;
  logic                  rf_we_w;
  logic                  err_div0_q, err_div0_d;
  logic [REG_AW-1:0]     err_rd_q, err_rd_d;

  assign push_entry = '{rd: wb_if.ex_rd, result: wb_if.ex_result, div0: wb_if.ex_div0};

  wb_fifo2 #(.entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .slots      (slots),
    .slot_valid (slot_valid),
    .rd_ptr     (rd_ptr),
    .full       (full),
    .empty      (empty),
    .count      (wb_count)
  );

  assign head = slots[rd_ptr];

  // No bypass when full: a slot must free at an edge before a new push.
  assign wb_if.ex_ready = !full;
  assign push           = wb_if.ex_valid && !full;

  assign droppable = head.div0 || (head.rd == '0);
  assign rf_we_w   = !empty && !droppable;
  assign pop       = (rf_we_w && wb_if.rf_wr_ready) || (!empty && droppable);

  assign wb_if.rf_we    = rf_we_w;
  assign wb_if.rf_waddr = rf_we_w ? head.rd : '0;
  assign wb_if.rf_wdata = rf_we_w ? head.result : '0;

  // r0 is hardwired zero, so it never needs a hazard bit.
  always_comb begin
    pending = '0;
    for (int s = 0; s < WB_DEPTH; s++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (slot_valid[s] && (slots[s].rd == REG_AW'(r))) pending[r] = 1'b1;
      end
    end
  end

  // A div0 retirement in the same cycle as err_clr wins and re-captures rd.
  always_comb begin
    err_div0_d = err_div0_q;
    err_rd_d   = err_rd_q;
    if (err_clr) begin
      err_div0_d = 1'b0;
      err_rd_d   = '0;
    end
    if (pop && head.div0) begin
      err_div0_d = 1'b1;
      if (!err_div0_q || err_clr) err_rd_d = head.rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_div0_q <= 1'b0;
      err_rd_q   <= '0;
    end else begin
      err_div0_q <= err_div0_d;
      err_rd_q   <= err_rd_d;
    end
  end

  assign err_div0 = err_div0_q;
  assign err_rd   = err_rd_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  localparam int W  = 8;
  localparam int NR = 8;
  localparam int AW = $clog2(NR);

  logic          clk;
  logic          rst;
  logic          err_clr;
  logic [NR-1:0] pending;
  logic [1:0]    wb_count;
  logic          err_div0;
  logic [AW-1:0] err_rd;

  alu_writeback_if #(.WIDTH(W), .NREGS(NR)) bus ();

  alu_writeback #(.WIDTH(W), .NREGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_if    (bus.slave),
    .pending  (pending),
    .wb_count (wb_count),
    .err_clr  (err_clr),
    .err_div0 (err_div0),
    .err_rd   (err_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  result;
    logic          exp_we;
    logic [NR-1:0] exp_pending;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs at the negedge: any write granted at the coming posedge must match
  // the oldest expected write; an idle port must present zero address/data.
  task automatic monitor();
    exp_t e;
    if (rst) return;
    if (bus.rf_we && bus.rf_wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0d/0x%0h expected=none", bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(e.addr));
        chk("wr_data", 32'(bus.rf_wdata), 32'(e.data));
      end
    end else if (!bus.rf_we) begin
      chk("idle_addr_data", {bus.rf_waddr, bus.rf_wdata}, 32'd0);
    end
  endtask

  // Advance one cycle: sample at negedge, return 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [AW-1:0] rd, input logic [W-1:0] res, input logic d0);
    exp_t e;
    bus.ex_valid  = 1'b1;
    bus.ex_rd     = rd;
    bus.ex_result = res;
    bus.ex_div0   = d0;
    if (!d0 && rd != '0) begin
      e.addr = rd;
      e.data = res;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_ex();
    bus.ex_valid  = 1'b0;
    bus.ex_rd     = '0;
    bus.ex_result = '0;
    bus.ex_div0   = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rd: 3'd3, result: 8'h2A, exp_we: 1'b1, exp_pending: 8'h08};
    vecs[1] = '{rd: 3'd7, result: 8'h80, exp_we: 1'b1, exp_pending: 8'h80};
    vecs[2] = '{rd: 3'd1, result: 8'h01, exp_we: 1'b1, exp_pending: 8'h02};
    vecs[3] = '{rd: 3'd0, result: 8'hFF, exp_we: 1'b0, exp_pending: 8'h00};
    vecs[4] = '{rd: 3'd6, result: 8'h00, exp_we: 1'b1, exp_pending: 8'h40};
    vecs[5] = '{rd: 3'd4, result: 8'hC3, exp_we: 1'b1, exp_pending: 8'h10};

    rst = 1'b1;
    err_clr = 1'b0;
    bus.rf_wr_ready = 1'b1;
    idle_ex();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    chk("rst_err_div0", 32'(err_div0), 32'd0);
    chk("rst_err_rd", 32'(err_rd), 32'd0);
    rst = 1'b0;
    step();

    // Single results, one at a time, register file always ready.
    for (int i = 0; i < 6; i++) begin
      drive_push(vecs[i].rd, vecs[i].result, 1'b0);
      step();
      idle_ex();
      chk($sformatf("vec%0d_rf_we", i), 32'(bus.rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
      chk($sformatf("vec%0d_count1", i), 32'(wb_count), 32'd1);
      step();
      chk($sformatf("vec%0d_count0", i), 32'(wb_count), 32'd0);
    end

    // Backpressure: fill both slots, hold, then release in order.
    bus.rf_wr_ready = 1'b0;
    drive_push(3'd1, 8'h11, 1'b0);
    step();
    drive_push(3'd2, 8'h22, 1'b0);
    step();
    idle_ex();
    chk("bp_count", 32'(wb_count), 32'd2);
    chk("bp_ex_ready", 32'(bus.ex_ready), 32'd0);
    chk("bp_pending", 32'(pending), 32'h06);
    step();
    step();
    chk("bp_hold_we", 32'(bus.rf_we), 32'd1);
    chk("bp_hold_addr", 32'(bus.rf_waddr), 32'd1);
    chk("bp_hold_data", 32'(bus.rf_wdata), 32'h11);
    bus.rf_wr_ready = 1'b1;
    step();
    chk("bp_second_addr", 32'(bus.rf_waddr), 32'd2);
    chk("bp_count_after1", 32'(wb_count), 32'd1);
    step();
    chk("bp_drained", 32'(wb_count), 32'd0);

    // Divide-by-zero drops and sticky error capture.
    drive_push(3'd5, 8'h99, 1'b1);
    step();
    idle_ex();
    chk("d0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("d0_pending", 32'(pending), 32'h20);
    chk("d0_count1", 32'(wb_count), 32'd1);
    step();
    chk("d0_count0", 32'(wb_count), 32'd0);
    chk("d0_err", 32'(err_div0), 32'd1);
    chk("d0_err_rd", 32'(err_rd), 32'd5);
    drive_push(3'd6, 8'h98, 1'b1);
    step();
    idle_ex();
    step();
    chk("d0_second_err", 32'(err_div0), 32'd1);
    chk("d0_second_rd_kept", 32'(err_rd), 32'd5);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("d0_clr_err", 32'(err_div0), 32'd0);
    chk("d0_clr_rd", 32'(err_rd), 32'd0);
    // Clear while a div0 retires: the new error survives with its rd.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("d0_clr_idle", 32'(err_div0), 32'd0);
    drive_push(3'd4, 8'h01, 1'b1);
    step();
    idle_ex();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("d0_clr_race_err", 32'(err_div0), 32'd1);
    chk("d0_clr_race_rd", 32'(err_rd), 32'd4);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Back-to-back pushes while the head retires: occupancy holds at 1.
    drive_push(3'd1, 8'h10, 1'b0);
    step();
    chk("sim_count_a", 32'(wb_count), 32'd1);
    drive_push(3'd2, 8'h20, 1'b0);
    step();
    chk("sim_count_b", 32'(wb_count), 32'd1);
    chk("sim_head_addr", 32'(bus.rf_waddr), 32'd2);
    drive_push(3'd3, 8'h30, 1'b0);
    step();
    idle_ex();
    chk("sim_count_c", 32'(wb_count), 32'd1);
    step();
    chk("sim_drained", 32'(wb_count), 32'd0);

    // Reset with two buffered entries: discarded, never written.
    bus.rf_wr_ready = 1'b0;
    drive_push(3'd1, 8'h44, 1'b0);
    step();
    drive_push(3'd2, 8'h55, 1'b0);
    step();
    idle_ex();
    chk("rstmid_count_pre", 32'(wb_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rstmid_count", 32'(wb_count), 32'd0);
    chk("rstmid_pending", 32'(pending), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    bus.rf_wr_ready = 1'b1;
    repeat (4) step();
    chk("rstmid_still_empty", 32'(wb_count), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
